// File: rtl/decode_writeback.sv
// Y86-64 PIPE decode/writeback stage: 15x64 register file, operand forwarding, E pipeline register.
// Optional RF_DEBUG_PORT_EN adds a combinational register-file observation port (dbg_rsel/dbg_rdata).
module decode_writeback #(
  parameter logic [3:0] RSP   = 4'h4,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RF_DEBUG_PORT_EN
  input  logic [3:0]  dbg_rsel,
  output logic [63:0] dbg_rdata,
`else
`endif
  input  logic [1:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [1:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{stat: 2'd0, icode: 4'h1, ifun: 4'h0,
                                  valC: '0, valA: '0, valB: '0,
                                  dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

  logic [14:0][63:0] rf;
  logic [3:0]        d_dstE, d_dstM;
  logic [63:0]       d_valA, d_valB;
  e_reg_t            e_q, e_d;

  function automatic logic [63:0] rf_rd(input logic [3:0] id);
    return (id == RNONE) ? 64'd0 : rf[id];
  endfunction

  // Forwarding priority: newest producer first; RNONE never matches a producer.
  function automatic logic [63:0] fwd(input logic [3:0] src);
    if (src == RNONE)       return 64'd0;
    else if (src == e_dstE) return e_valE;
    else if (src == M_dstM) return m_valM;
    else if (src == M_dstE) return M_valE;
    else if (src == W_dstM) return W_valM;
    else if (src == W_dstE) return W_valE;
    else                    return rf_rd(src);
  endfunction

  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;
    case (D_icode)
      4'h2: begin d_srcA = D_rA; d_dstE = D_rB; end
      4'h3: d_dstE = D_rB;
      4'h4: begin d_srcA = D_rA; d_srcB = D_rB; end
      4'h5: begin d_srcB = D_rB; d_dstM = D_rA; end
      4'h6: begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
      4'h8: begin d_srcB = RSP;  d_dstE = RSP; end
      4'h9: begin d_srcA = RSP;  d_srcB = RSP; d_dstE = RSP; end
      4'hA: begin d_srcA = D_rA; d_srcB = RSP; d_dstE = RSP; end
      4'hB: begin d_srcA = RSP;  d_srcB = RSP; d_dstE = RSP; d_dstM = D_rA; end
      default: ;
    endcase
  end

  // call/jXX carry valP down the pipe in valA.
  always_comb begin
    d_valA = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : fwd(d_srcA);
    d_valB = fwd(d_srcB);
  end

  always_comb begin
    e_d = E_bubble ? E_BUBBLE
                   : '{stat: D_stat, icode: D_icode, ifun: D_ifun, valC: D_valC,
                       valA: d_valA, valB: d_valB, dstE: d_dstE, dstM: d_dstM,
                       srcA: d_srcA, srcB: d_srcB};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= E_BUBBLE;
    else        e_q <= e_d;
  end

  // Port M takes precedence on a shared address (popq %rsp).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (W_dstM == 4'(i))      rf[i] <= W_valM;
        else if (W_dstE == 4'(i)) rf[i] <= W_valE;
      end
    end
  end

`ifdef RF_DEBUG_PORT_EN
  assign dbg_rdata = rf_rd(dbg_rsel);
`else
`endif

  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valC;
  assign E_valA  = e_q.valA;
  assign E_valB  = e_q.valB;
  assign E_dstE  = e_q.dstE;
  assign E_dstM  = e_q.dstM;
  assign E_srcA  = e_q.srcA;
  assign E_srcB  = e_q.srcB;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: expected E contents queued at drive time, checked one cycle later.
module tb_decode_writeback;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } e_t;

  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  D_stat = '0;
  logic [3:0]  D_icode = 4'h1, D_ifun = '0, D_rA = F, D_rB = F;
  logic [63:0] D_valC = '0, D_valP = '0;
  logic [3:0]  e_dstE = F, M_dstE = F, M_dstM = F, W_dstE = F, W_dstM = F;
  logic [63:0] e_valE = '0, M_valE = '0, m_valM = '0, W_valE = '0, W_valM = '0;
  logic        E_bubble = 1'b0;
  logic [3:0]  d_srcA, d_srcB;
  logic [1:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
`ifdef RF_DEBUG_PORT_EN
  logic [3:0]  dbg_rsel = '0;
  logic [63:0] dbg_rdata;
`endif

  int n_vec = 0;
  int n_err = 0;
  e_t sb[$];
  e_t exp_e, obs;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RF_DEBUG_PORT_EN
    .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata),
`endif
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .E_bubble(E_bubble),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  assign obs = '{stat: E_stat, icode: E_icode, ifun: E_ifun, valC: E_valC, valA: E_valA,
                 valB: E_valB, dstE: E_dstE, dstM: E_dstM, srcA: E_srcA, srcB: E_srcB};

  function automatic e_t mk(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                            input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                            input logic [3:0] de, input logic [3:0] dm,
                            input logic [3:0] sa, input logic [3:0] sbr);
    return '{stat: st, icode: ic, ifun: fn, valC: vc, valA: va, valB: vb,
             dstE: de, dstM: dm, srcA: sa, srcB: sbr};
  endfunction

  function automatic e_t bub();
    return mk(2'd0, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F);
  endfunction

  task automatic clr_fwd();
    e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F;
    e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
  endtask

  // Drive one D instruction, queue its expected E value, advance one cycle.
  task automatic step(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [3:0] ra, input logic [3:0] rb,
                      input logic [63:0] vc, input logic [63:0] vp, input e_t e);
    D_stat = st; D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_vec++;
    if (obs !== bub()) begin
      n_err++; $display("FAIL reset_E got=%h want=%h", obs, bub());
    end
`ifdef RF_DEBUG_PORT_EN
    for (int r = 0; r < 16; r++) begin
      dbg_rsel = 4'(r); #1;
      n_vec++;
      if (dbg_rdata !== 64'd0) begin
        n_err++; $display("FAIL reset_rf[%0d] got=%h want=0", r, dbg_rdata);
      end
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_rf_write();
    clr_fwd(); W_dstE = 4'd3; W_valE = 64'h55;
    step(0, 4'h1, 0, F, F, 0, 0, bub());
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL wb_nop got=%h want=%h", obs, exp_e); end
    clr_fwd();
    step(0, 4'h2, 0, 4'd3, 4'd2, 0, 0, mk(0, 4'h2, 0, 0, 64'h55, 0, 4'd2, F, 4'd3, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL rrmovq_rf got=%h want=%h", obs, exp_e); end
  endtask

  task automatic test_forward_priority();
    clr_fwd();
    e_dstE = 4'd1; e_valE = 64'd7; M_dstE = 4'd1; M_valE = 64'd9; M_dstM = 4'd2; m_valM = 64'hAB;
    step(0, 4'h6, 4'h0, 4'd1, 4'd2, 0, 0, mk(0, 4'h6, 0, 0, 64'd7, 64'hAB, 4'd2, F, 4'd1, 4'd2));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL fwd_e_over_M got=%h want=%h", obs, exp_e); end
    clr_fwd(); M_dstE = 4'd2; M_valE = 64'd9; M_dstM = 4'd2; m_valM = 64'hAB;
    step(0, 4'h6, 4'h1, 4'd2, 4'd2, 0, 0, mk(0, 4'h6, 4'h1, 0, 64'hAB, 64'hAB, 4'd2, F, 4'd2, 4'd2));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL fwd_mM_over_ME got=%h want=%h", obs, exp_e); end
    clr_fwd(); W_dstE = 4'd5; W_valE = 64'h77;
    step(0, 4'h2, 0, 4'd5, 4'd1, 0, 0, mk(0, 4'h2, 0, 0, 64'h77, 0, 4'd1, F, 4'd5, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL fwd_WE got=%h want=%h", obs, exp_e); end
    clr_fwd(); W_dstE = 4'd6; W_valE = 64'hB2; W_dstM = 4'd6; W_valM = 64'hA1;
    step(0, 4'h2, 0, 4'd6, 4'd1, 0, 0, mk(0, 4'h2, 0, 0, 64'hA1, 0, 4'd1, F, 4'd6, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL fwd_WM_over_WE got=%h want=%h", obs, exp_e); end
    clr_fwd(); e_valE = 64'hDEAD; M_valE = 64'hBEEF; m_valM = 64'hCAFE;
    step(0, 4'h1, 0, F, F, 0, 0, bub());
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL fwd_rnone got=%h want=%h", obs, exp_e); end
  endtask

  task automatic test_call();
    clr_fwd(); W_dstE = 4'd4; W_valE = 64'h100;
    step(0, 4'h1, 0, F, F, 0, 0, bub());
    exp_e = sb.pop_front();
    clr_fwd();
    step(0, 4'h8, 0, F, F, 64'h200, 64'h40, mk(0, 4'h8, 0, 64'h200, 64'h40, 64'h100, 4'd4, F, F, 4'd4));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL call got=%h want=%h", obs, exp_e); end
    step(0, 4'h7, 4'h3, F, F, 64'h300, 64'h99, mk(0, 4'h7, 4'h3, 64'h300, 64'h99, 0, F, F, F, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL jxx got=%h want=%h", obs, exp_e); end
  endtask

  task automatic test_wb_collision();
    clr_fwd(); W_dstE = 4'd4; W_valE = 64'h10; W_dstM = 4'd4; W_valM = 64'h20;
    step(0, 4'h1, 0, F, F, 0, 0, bub());
    exp_e = sb.pop_front();
    clr_fwd();
    step(0, 4'h2, 0, 4'd4, 4'd0, 0, 0, mk(0, 4'h2, 0, 0, 64'h20, 0, 4'd0, F, 4'd4, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL wb_collision got=%h want=%h", obs, exp_e); end
  endtask

  task automatic test_decode_misc();
    clr_fwd();
    D_icode = 4'hB; D_rA = 4'd6; D_rB = F; #1;
    n_vec++;
    if ({d_srcA, d_srcB} !== {4'd4, 4'd4}) begin
      n_err++; $display("FAIL comb_src got=%h want=44", {d_srcA, d_srcB});
    end
    step(0, 4'hB, 0, 4'd6, F, 0, 0, mk(0, 4'hB, 0, 0, 64'h20, 64'h20, 4'd4, 4'd6, 4'd4, 4'd4));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL popq got=%h want=%h", obs, exp_e); end
    step(0, 4'h5, 0, 4'd2, 4'd3, 64'h8, 0, mk(0, 4'h5, 0, 64'h8, 0, 64'h55, F, 4'd2, F, 4'd3));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL mrmovq got=%h want=%h", obs, exp_e); end
    step(0, 4'h3, 0, F, 4'd7, 64'h1234, 0, mk(0, 4'h3, 0, 64'h1234, 0, 0, 4'd7, F, F, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL irmovq got=%h want=%h", obs, exp_e); end
    step(2'd3, 4'hC, 4'h5, 4'd1, 4'd2, 64'h9, 0, mk(2'd3, 4'hC, 4'h5, 64'h9, 0, 0, F, F, F, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL invalid got=%h want=%h", obs, exp_e); end
    step(2'd1, 4'h0, 0, 4'd1, 4'd2, 0, 0, mk(2'd1, 4'h0, 0, 0, 0, 0, F, F, F, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL halt got=%h want=%h", obs, exp_e); end
  endtask

  task automatic test_bubble_reset();
    clr_fwd(); E_bubble = 1'b1;
    step(0, 4'h3, 0, F, 4'd7, 64'h1234, 0, bub());
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL bubble got=%h want=%h", obs, exp_e); end
    E_bubble = 1'b0;
    step(0, 4'h3, 0, F, 4'd7, 64'h1234, 0, mk(0, 4'h3, 0, 64'h1234, 0, 0, 4'd7, F, F, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL post_bubble got=%h want=%h", obs, exp_e); end
    #2 rst_n = 1'b0; #1;
    n_vec++;
    if (obs !== bub()) begin n_err++; $display("FAIL async_reset got=%h want=%h", obs, bub()); end
    W_dstE = 4'd4; W_valE = 64'h99;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_fwd();
    step(0, 4'h2, 0, 4'd4, 4'd0, 0, 0, mk(0, 4'h2, 0, 0, 0, 0, 4'd0, F, 4'd4, F));
    exp_e = sb.pop_front(); n_vec++;
    if (obs !== exp_e) begin n_err++; $display("FAIL reset_rf_clear got=%h want=%h", obs, exp_e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rf_write();
    test_forward_priority();
    test_call();
    test_wb_collision();
    test_decode_misc();
    test_bubble_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 PIPE decode/writeback stage. It consumes the D pipeline register produced by fetch and owns the 15x64 program register file, written from the W stage.
- Resolves operands with forwarding from the e, M and W stages.
- Produces the E pipeline register, with bubble insertion from pipeline control.
- Also exports combinational d_srcA/d_srcB to the hazard unit, which uses them for load/use detection.

Parameters:
- RSP, 4'h4: stack pointer register ID.
- RNONE, 4'hF: "no register" ID.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- D_stat  in  2  fetch status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- D_icode  in  4  instruction code.
- D_ifun  in  4  function code.
- D_rA  in  4  register specifier A.
- D_rB  in  4  register specifier B.
- D_valC  in  64  constant word.
- D_valP  in  64  incremented PC.
- e_dstE  in  4  execute-stage destination register for valE (combinational).
- e_valE  in  64  execute-stage ALU result (combinational).
- M_dstE  in  4  M register dstE.
- M_valE  in  64  M register valE.
- M_dstM  in  4  M register dstM.
- m_valM  in  64  memory read data.
- W_dstE  in  4  W register dstE; also the register-file write port E address.
- W_valE  in  64  W register valE; also the register-file write port E data.
- W_dstM  in  4  W register dstM; also the register-file write port M address.
- W_valM  in  64  W register valM; also the register-file write port M data.
- E_bubble  in  1  load a bubble into E at the next posedge.
- d_srcA  out  4  combinational source A register ID.
- d_srcB  out  4  combinational source B register ID.
- E_stat, E_icode, E_ifun  out  2/4/4  E register fields.
- E_valC, E_valA, E_valB  out  64 each  E register data.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  E register register IDs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all 15 registers cleared to 0.
  - E loads the bubble value: stat=0, icode=4'h1 (nop), ifun=0, valC=valA=valB=0, dstE=dstM=srcA=srcB=RNONE.
  - Reset asserted mid-operation discards any pending write.
- d_srcA: rA for icode 2/4/6/A; RSP for icode 9/B; otherwise RNONE.
- d_srcB: rB for icode 4/5/6; RSP for icode 8/9/A/B; otherwise RNONE.
- d_dstE: rB for icode 2/3/6; RSP for icode 8/9/A/B; otherwise RNONE. Cmov suppression happens in execute, not here.
- d_dstM: rA for icode 5/B; otherwise RNONE.
- d_valA selection, first match wins:
  1. icode 7 or 8: D_valP.
  2. srcA==e_dstE: e_valE.
  3. srcA==M_dstM: m_valM.
  4. srcA==M_dstE: M_valE.
  5. srcA==W_dstM: W_valM.
  6. srcA==W_dstE: W_valE.
  7. Otherwise: register file.
- d_valB: same priority chain on srcB, without the valP case.
- Forwarding never matches when the source ID is RNONE. A read of RNONE returns 0.
- Register file reads are combinational and return the pre-write value. Same-cycle write visibility comes only through W forwarding.
- Writeback at posedge:
  - rf[W_dstE] <= W_valE if W_dstE != RNONE.
  - rf[W_dstM] <= W_valM if W_dstM != RNONE.
  - If W_dstE == W_dstM (popq %rsp case), W_valM wins.
- E register update at posedge:
  - If E_bubble: load the bubble value.
  - Otherwise: load D_stat, D_icode, D_ifun, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB.
- Latency: one cycle from the D inputs to the E outputs.
- E has no stall input; pipeline control only ever bubbles E.
- D_stat passes through unchanged, including for halt (icode 0) and invalid instructions.
- Invalid icodes (C–F) decode all IDs to RNONE.

Optional Feature:
- Macro: RF_DEBUG_PORT_EN.
- When defined, adds two ports:
  - dbg_rsel  in  4  register to observe.
  - dbg_rdata  out  64  combinational read of rf[dbg_rsel]; returns 0 for RNONE.
- When not defined, neither port exists, and core behaviour is identical in both builds.

Test Plan:
1. rst_n low, then release → E_icode=1, E_dstE=F, E_srcA=F. Debug reads of all registers return 0.
2. W_dstE=3, W_valE=0x55; next cycle D = rrmovq rA=3 rB=2 (icode 2) → E_valA=0x55, E_dstE=2, E_srcA=3.
3. D = OPq rA=1 rB=2 (icode 6) with e_dstE=1, e_valE=7 and M_dstE=1, M_valE=9, plus M_dstM=2, m_valM=0xAB → E_valA=7 (e wins over M), E_valB=0xAB.
4. D = call (icode 8), valP=0x40, rsp=0x100 → E_valA=0x40, E_valB=0x100, E_srcB=4, E_dstE=4.
5. W_dstE=4, W_valE=0x10 together with W_dstM=4, W_valM=0x20 → rf[4]=0x20.
6. E_bubble=1 while D = irmovq → E_icode=1, E_dstE=F. Asserting rst_n low mid-cycle clears E immediately.
